morra_round_sequencer: RTL and testbench

MORRA_ROUND_SEQUENCER -- requirements
Module: morra_round_sequencer

---
 rtl/morra_pkg.sv | 25 ++
 rtl/morra_move_slot.sv | 39 +++
 rtl/morra_round_sequencer.sv | 128 ++++++++++++
 tb/tb_morra_round_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/morra_pkg.sv
// Shared types for the Morra round sequencer: FSM states and the 2-bit
// move / MANCHE / PARTITA encoding used on both sides of the core.
package morra_pkg;

    localparam int NUM_PLAYERS = 2;
    localparam int VR_W        = 5;
    localparam logic [VR_W-1:0] VR_MAX = 5'd31;

    typedef enum logic [2:0] {
        IDLE, START, COLLECT, ISSUE, WAIT_RES, DONE, FLUSH
    } state_t;

    // 00 none/invalid, 01 player-1, 10 player-2, 11 draw/tie
    typedef enum logic [1:0] {
        ENC_NONE = 2'b00,
        ENC_P1   = 2'b01,
        ENC_P2   = 2'b10,
        ENC_TIE  = 2'b11
    } enc_t;

    function automatic logic [VR_W-1:0] sat_inc(input logic [VR_W-1:0] v);
        return (v == VR_MAX) ? v : v + 5'd1;
    endfunction

endpackage

// File: rtl/morra_move_slot.sv
// One player's move holder: valid/ready capture, held until the sequencer
// issues it, ready registered and only raised when the next cycle collects.
module morra_move_slot
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arm,
    input  logic       clear,
    input  logic       valid,
    input  logic [1:0] move,
    output logic       ready,
    output logic       held,
    output logic [1:0] held_move
);

    logic take;
    logic held_nx;

    assign take    = valid & ready;
    assign held_nx = ~clear & (held | take);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready     <= 1'b0;
            held      <= 1'b0;
            held_move <= ENC_NONE;
        end else begin
            held  <= held_nx;
            // ready drops in the same edge that captures, so a move is never overwritten
            ready <= arm & ~held_nx;
            if (clear)
                held_move <= ENC_NONE;
            else if (take)
                held_move <= move;
        end
    end

endmodule

// File: rtl/morra_round_sequencer.sv
// Drives a MorraCinese core through start / per-round issue / flush and
// reports each round's result plus a saturating count of decided rounds.
module morra_round_sequencer
    import morra_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_req,
    input  logic [3:0]      start_max,
    output logic            start_ack,
    input  logic            p1_valid,
    input  logic [1:0]      p1_move,
    output logic            p1_ready,
    input  logic            p2_valid,
    input  logic [1:0]      p2_move,
    output logic            p2_ready,
    output logic [1:0]      core_primo,
    output logic [1:0]      core_secondo,
    output logic            core_inizia,
    input  logic [1:0]      core_manche,
    input  logic [1:0]      core_partita,
    output logic            res_valid,
    output logic [1:0]      res_manche,
    output logic [1:0]      res_partita,
    output logic            game_over,
    output logic            busy,
    output logic [VR_W-1:0] valid_rounds
);

    state_t state;

    logic [NUM_PLAYERS-1:0]      pl_valid, pl_ready, pl_held;
    logic [NUM_PLAYERS-1:0][1:0] pl_move, pl_hmove;
    logic                        both_held, arm, clr;

    assign pl_valid  = {p2_valid, p1_valid};
    assign pl_move   = {p2_move, p1_move};
    assign p1_ready  = pl_ready[0];
    assign p2_ready  = pl_ready[1];
    assign both_held = &pl_held;
    assign clr       = (state == ISSUE);

    // true when the cycle after this edge is a COLLECT cycle
    assign arm = (state == START)
               | ((state == COLLECT) & ~both_held)
               | ((state == WAIT_RES) & (core_partita == ENC_NONE));

    genvar g;
    generate
        for (g = 0; g < NUM_PLAYERS; g++) begin : g_slot
            morra_move_slot u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .arm       (arm),
                .clear     (clr),
                .valid     (pl_valid[g]),
                .move      (pl_move[g]),
                .ready     (pl_ready[g]),
                .held      (pl_held[g]),
                .held_move (pl_hmove[g])
            );
        end
    endgenerate

    // Outputs are loaded on the edge entering a state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            start_ack    <= 1'b0;
            core_primo   <= ENC_NONE;
            core_secondo <= ENC_NONE;
            core_inizia  <= 1'b0;
            res_valid    <= 1'b0;
            res_manche   <= ENC_NONE;
            res_partita  <= ENC_NONE;
            game_over    <= 1'b0;
            busy         <= 1'b0;
            valid_rounds <= '0;
        end else begin
            start_ack    <= 1'b0;
            core_primo   <= ENC_NONE;
            core_secondo <= ENC_NONE;
            core_inizia  <= 1'b0;
            res_valid    <= 1'b0;
            res_manche   <= ENC_NONE;
            res_partita  <= ENC_NONE;
            game_over    <= 1'b0;
            case (state)
                IDLE: if (start_req) begin
                    start_ack    <= 1'b1;
                    core_inizia  <= 1'b1;
                    core_primo   <= start_max[3:2];
                    core_secondo <= start_max[1:0];
                    valid_rounds <= '0;
                    busy         <= 1'b1;
                    state        <= START;
                end
                START: state <= COLLECT;
                COLLECT: if (both_held) begin
                    core_primo   <= pl_hmove[0];
                    core_secondo <= pl_hmove[1];
                    state        <= ISSUE;
                end
                ISSUE: state <= WAIT_RES;
                WAIT_RES: begin
                    res_valid   <= 1'b1;
                    res_manche  <= core_manche;
                    res_partita <= core_partita;
                    if (core_manche != ENC_NONE)
                        valid_rounds <= sat_inc(valid_rounds);
                    if (core_partita != ENC_NONE) begin
                        game_over <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= COLLECT;
                    end
                end
                DONE: state <= FLUSH;
                FLUSH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morra_round_sequencer.sv
// Directed vector table, reset corner cases, then randomized play checked
// against an event-scheduled model of the sequencer.
module tb_morra_round_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_req = 1'b0;
    logic [3:0] start_max = '0;
    logic       p1_valid = 1'b0, p2_valid = 1'b0;
    logic [1:0] p1_move = '0, p2_move = '0;
    logic [1:0] core_manche = '0, core_partita = '0;
    logic       start_ack, p1_ready, p2_ready, core_inizia;
    logic [1:0] core_primo, core_secondo, res_manche, res_partita;
    logic       res_valid, game_over, busy;
    logic [4:0] valid_rounds;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    morra_round_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .start_req(start_req), .start_max(start_max), .start_ack(start_ack),
        .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
        .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
        .core_primo(core_primo), .core_secondo(core_secondo), .core_inizia(core_inizia),
        .core_manche(core_manche), .core_partita(core_partita),
        .res_valid(res_valid), .res_manche(res_manche), .res_partita(res_partita),
        .game_over(game_over), .busy(busy), .valid_rounds(valid_rounds)
    );

    // {ack, inizia, primo, secondo, rdy1, rdy2, res_valid, manche, partita, game_over, busy, rounds}
    logic [19:0] act;
    assign act = {start_ack, core_inizia, core_primo, core_secondo, p1_ready, p2_ready,
                  res_valid, res_manche, res_partita, game_over, busy, valid_rounds};

    // {start_req, start_max, p1v, p1m, p2v, p2m, core_manche, core_partita}
    typedef struct {
        logic [14:0] in;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[20];

    task automatic drive_in(input logic [14:0] v);
        {start_req, start_max, p1_valid, p1_move, p2_valid, p2_move, core_manche, core_partita} = v;
    endtask

    task automatic chk(input string nm, input logic [19:0] a, input logic [19:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", nm, a, e);
        end
    endtask

    // Behavioural model: schedules events by cycle number from the rules.
    localparam int INF = 32'h3fff_ffff;
    int   n, idle_from, collect_from, issue_cyc, res_cyc, vr;
    bit   h1, h2, pr1, pr2;
    logic [1:0] m1, m2;

    function automatic void model_reset();
        n = 0; idle_from = 0; collect_from = INF; issue_cyc = -1; res_cyc = -1;
        vr = 0; h1 = 0; h2 = 0; pr1 = 0; pr2 = 0; m1 = 0; m2 = 0;
    endfunction

    function automatic logic [19:0] model_step();
        logic ack, ini, rv, go, r1, r2, bz;
        logic [1:0] pr, se, rm, rp;
        logic [4:0] vr5;
        n++;
        ack = 0; ini = 0; rv = 0; go = 0; pr = 0; se = 0; rm = 0; rp = 0;
        if (pr1 && p1_valid) begin h1 = 1; m1 = p1_move; end
        if (pr2 && p2_valid) begin h2 = 1; m2 = p2_move; end
        if (n - 1 >= idle_from && start_req) begin
            ack = 1; ini = 1; pr = start_max[3:2]; se = start_max[1:0];
            vr = 0; idle_from = INF; collect_from = n + 1;
        end
        if (n == issue_cyc) begin
            pr = m1; se = m2; h1 = 0; h2 = 0;
        end
        if (n == res_cyc) begin
            rv = 1; rm = core_manche; rp = core_partita;
            if (core_manche != 0 && vr < 31) vr++;
            if (core_partita != 0) begin go = 1; idle_from = n + 2; end
            else collect_from = n;
        end
        r1 = (n >= collect_from) && !h1;
        r2 = (n >= collect_from) && !h2;
        if (n >= collect_from && h1 && h2) begin
            collect_from = INF; issue_cyc = n + 1; res_cyc = n + 3;
        end
        bz = !(n >= idle_from);
        pr1 = r1; pr2 = r2;
        vr5 = vr[4:0];
        return {ack, ini, pr, se, r1, r2, rv, rm, rp, go, bz, vr5};
    endfunction

    initial begin
        tbl[0]  = '{15'b1_0000_0_00_0_00_00_00, 20'b1_1_00_00_0_0_0_00_00_0_1_00000};
        tbl[1]  = '{15'b0_0000_0_00_0_00_00_00, 20'b0_0_00_00_1_1_0_00_00_0_1_00000};
        tbl[2]  = '{15'b0_0000_1_10_0_00_00_00, 20'b0_0_00_00_0_1_0_00_00_0_1_00000};
        tbl[3]  = '{15'b1_0000_1_01_0_00_00_00, 20'b0_0_00_00_0_1_0_00_00_0_1_00000};
        tbl[4]  = '{15'b1_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_1_0_00_00_0_1_00000};
        tbl[5]  = '{15'b1_0000_0_00_1_11_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00000};
        tbl[6]  = '{15'b1_0000_1_01_1_01_00_00, 20'b0_0_10_11_0_0_0_00_00_0_1_00000};
        tbl[7]  = '{15'b1_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00000};
        tbl[8]  = '{15'b1_0000_0_00_0_00_10_00, 20'b0_0_00_00_1_1_1_10_00_0_1_00001};
        tbl[9]  = '{15'b1_0000_1_00_1_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00001};
        tbl[10] = '{15'b1_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00001};
        tbl[11] = '{15'b1_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00001};
        tbl[12] = '{15'b1_0000_0_00_0_00_00_01, 20'b0_0_00_00_0_0_1_00_01_1_1_00001};
        tbl[13] = '{15'b1_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00001};
        tbl[14] = '{15'b1_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_0_00001};
        tbl[15] = '{15'b1_1011_0_00_0_00_00_00, 20'b1_1_10_11_0_0_0_00_00_0_1_00000};
        tbl[16] = '{15'b0_0000_0_00_0_00_00_00, 20'b0_0_00_00_1_1_0_00_00_0_1_00000};
        tbl[17] = '{15'b0_0000_1_01_1_10_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00000};
        tbl[18] = '{15'b0_0000_0_00_0_00_00_00, 20'b0_0_01_10_0_0_0_00_00_0_1_00000};
        tbl[19] = '{15'b0_0000_0_00_0_00_00_00, 20'b0_0_00_00_0_0_0_00_00_0_1_00000};

        #12;
        chk("reset_state", act, 20'b0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive_in(tbl[i].in);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), act, tbl[i].exp);
        end

        // Row 19 leaves the DUT in WAIT_RES: reset must clear everything at once.
        rst_n = 1'b0; #1;
        chk("reset_mid_game", act, 20'b0);
        drive_in(15'b0);
        @(posedge clk); #1;
        chk("reset_held", act, 20'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", act, 20'b0);
        drive_in(15'b1_0101_0_00_0_00_00_00);
        @(posedge clk); #1;
        chk("restart_ack", act, 20'b1_1_01_01_0_0_0_00_00_0_1_00000);
        drive_in(15'b0);
        @(posedge clk); #1;
        chk("restart_collect", act, 20'b0_0_00_00_1_1_0_00_00_0_1_00000);

        // Randomized play against the model; second half never ends a game.
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [19:0] e;
            start_req    = ($urandom_range(0, 3) == 0);
            start_max    = 4'($urandom);
            p1_valid     = $urandom_range(0, 1) != 0;
            p2_valid     = $urandom_range(0, 1) != 0;
            p1_move      = 2'($urandom);
            p2_move      = 2'($urandom);
            core_manche  = 2'($urandom);
            core_partita = (c < 1500 && $urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            @(posedge clk);
            e = model_step();
            #1;
            chk($sformatf("rand_cyc%0d", c), act, e);
        end
        chk("rounds_saturated", {15'b0, valid_rounds}, 20'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
